// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// mc_ctrl_pkg : state, opcode and datapath-select encodings for the
//               multicycle control unit.  MC_CTRL_JUMP_EN adds the JUMP state.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      st_start    = 4'd0,
      st_fetch    = 4'd1,
      st_decode   = 4'd2,
      st_mem_addr = 4'd3,
      st_mem_rd   = 4'd4,
      st_mem_wr   = 4'd5,
      st_mem_wb   = 4'd6,
      st_exec_r   = 4'd7,
      st_r_wb     = 4'd8,
      st_exec_i   = 4'd9,
      st_i_wb     = 4'd10,
      st_branch   = 4'd11,
`ifdef MC_CTRL_JUMP_EN
      st_jump     = 4'd12,
`endif
      st_trap     = 4'd15
   } state_t;

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_j     = 6'b000010;

   localparam logic [1:0] c_aluop_add   = 2'b00;
   localparam logic [1:0] c_aluop_sub   = 2'b01;
   localparam logic [1:0] c_aluop_funct = 2'b10;

   localparam logic [1:0] c_srcb_reg  = 2'b00;
   localparam logic [1:0] c_srcb_four = 2'b01;
   localparam logic [1:0] c_srcb_imm  = 2'b10;
   localparam logic [1:0] c_srcb_imm2 = 2'b11;

   localparam logic [1:0] c_pcsrc_alu    = 2'b00;
   localparam logic [1:0] c_pcsrc_aluout = 2'b01;
   localparam logic [1:0] c_pcsrc_jump   = 2'b10;

   localparam logic [1:0] c_cause_none    = 2'b00;
   localparam logic [1:0] c_cause_illegal = 2'b01;
   localparam logic [1:0] c_cause_timeout = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// ============================================================================
// mc_wait_timer : memory wait-cycle counter; expired flags the last permitted
//                 stall cycle.  MEM_TIMEOUT = 0 never expires.
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (count) begin
         r_count <= r_count + CW'(1);
      end
   end

   // Expires on the stall cycle that would bring the count up to MEM_TIMEOUT
   generate
      if (MEM_TIMEOUT > 0) begin : g_timeout
         assign expired = count && (r_count == CW'(MEM_TIMEOUT - 1));
      end else begin : g_no_timeout
         assign expired = 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// multicycle_control_unit : multicycle MIPS-style control FSM with memory
//                           timeout and illegal-opcode trap.  MC_CTRL_JUMP_EN
//                           enables the j instruction.
// Revision                : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       instr_done,
   output logic       trap,
   output logic [1:0] trap_cause
);

   state_t     r_state;
   state_t     w_next_state;
   logic [1:0] r_trap_cause;
   logic [1:0] w_trap_cause_next;
   logic       w_wait_state;
   logic       w_timer_count;
   logic       w_timer_clear;
   logic       w_timer_expired;
   logic       w_unused;

   // zero only gates the PC write inside the datapath
   assign w_unused = zero;

   assign w_wait_state  = (r_state == st_fetch) || (r_state == st_mem_rd) ||
                          (r_state == st_mem_wr);
   assign w_timer_count = w_wait_state && !mem_ready;
   assign w_timer_clear = (w_next_state != r_state);

   mc_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_timer_clear),
      .count   (w_timer_count),
      .expired (w_timer_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= st_start;
         r_trap_cause <= c_cause_none;
      end else begin
         r_state <= w_next_state;
         if (w_next_state == st_trap && r_state != st_trap) begin
            r_trap_cause <= w_trap_cause_next;
         end
      end
   end

   always_comb begin
      w_next_state      = r_state;
      w_trap_cause_next = c_cause_none;
      case (r_state)
         st_start:    w_next_state = st_fetch;
         st_fetch: begin
            if (mem_ready) begin
               w_next_state = st_decode;
            end else if (w_timer_expired) begin
               w_next_state      = st_trap;
               w_trap_cause_next = c_cause_timeout;
            end
         end
         st_decode: begin
            case (opcode)
               c_op_lw, c_op_sw: w_next_state = st_mem_addr;
               c_op_rtype:       w_next_state = st_exec_r;
               c_op_addi:        w_next_state = st_exec_i;
               c_op_beq:         w_next_state = st_branch;
`ifdef MC_CTRL_JUMP_EN
               c_op_j:           w_next_state = st_jump;
`endif
               default: begin
                  w_next_state      = st_trap;
                  w_trap_cause_next = c_cause_illegal;
               end
            endcase
         end
         st_mem_addr: w_next_state = (opcode == c_op_lw) ? st_mem_rd : st_mem_wr;
         st_mem_rd: begin
            if (mem_ready) begin
               w_next_state = st_mem_wb;
            end else if (w_timer_expired) begin
               w_next_state      = st_trap;
               w_trap_cause_next = c_cause_timeout;
            end
         end
         st_mem_wr: begin
            if (mem_ready) begin
               w_next_state = st_fetch;
            end else if (w_timer_expired) begin
               w_next_state      = st_trap;
               w_trap_cause_next = c_cause_timeout;
            end
         end
         st_exec_r:   w_next_state = st_r_wb;
         st_exec_i:   w_next_state = st_i_wb;
         st_mem_wb, st_r_wb, st_i_wb, st_branch: w_next_state = st_fetch;
`ifdef MC_CTRL_JUMP_EN
         st_jump:     w_next_state = st_fetch;
`endif
         st_trap:     w_next_state = st_trap;
         default:     w_next_state = st_start;
      endcase
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = c_srcb_reg;
      ALUOp       = c_aluop_add;
      PCSource    = c_pcsrc_alu;
      instr_done  = 1'b0;
      trap        = 1'b0;
      trap_cause  = r_trap_cause;
      case (r_state)
         st_fetch: begin
            MemRead = 1'b1;
            ALUSrcB = c_srcb_four;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         st_decode:   ALUSrcB = c_srcb_imm2;
         st_mem_addr, st_exec_i: begin
            ALUSrcA = 1'b1;
            ALUSrcB = c_srcb_imm;
         end
         st_exec_r: begin
            ALUSrcA = 1'b1;
            ALUOp   = c_aluop_funct;
         end
         st_mem_rd: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         st_mem_wr: begin
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            instr_done = mem_ready;
         end
         st_mem_wb: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
         end
         st_r_wb: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            instr_done = 1'b1;
         end
         st_i_wb: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         st_branch: begin
            ALUSrcA     = 1'b1;
            ALUOp       = c_aluop_sub;
            PCWriteCond = 1'b1;
            PCSource    = c_pcsrc_aluout;
            instr_done  = 1'b1;
         end
`ifdef MC_CTRL_JUMP_EN
         st_jump: begin
            PCWrite    = 1'b1;
            PCSource   = c_pcsrc_jump;
            instr_done = 1'b1;
         end
`endif
         st_trap:     trap = 1'b1;
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// tb_multicycle_control_unit : randomized instruction-level bench for the
//                              multicycle control unit (MEM_TIMEOUT = 4).
// Revision                   : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

   localparam int TO = 4;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource, trap_cause;
   logic       instr_done, trap;
   logic [20:0] obs;

   int n_tests = 0;
   int n_fail  = 0;
   int g_cyc   = 0;
   int g_done_at = 0;

   multicycle_control_unit #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause)
   );

   always #5 clk = ~clk;

   assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                 instr_done, trap, trap_cause};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected control word for one cycle of a named instruction step
   function automatic logic [20:0] vec_for(input string step, input logic [1:0] cause);
      logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, done, trp;
      logic [1:0] srcb, aluop, pcsrc, tc;
      {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, done, trp} = '0;
      srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00; tc = 2'b00;
      case (step)
         "fetch":     begin mrd = 1; srcb = 2'b01; end
         "fetch_go":  begin mrd = 1; srcb = 2'b01; irw = 1; pcw = 1; end
         "decode":    srcb = 2'b11;
         "mem_addr", "exec_i": begin srca = 1; srcb = 2'b10; end
         "exec_r":    begin srca = 1; aluop = 2'b10; end
         "mem_rd":    begin mrd = 1; iord = 1; end
         "mem_wr":    begin mwr = 1; iord = 1; end
         "mem_wr_go": begin mwr = 1; iord = 1; done = 1; end
         "mem_wb":    begin rw = 1; m2r = 1; done = 1; end
         "r_wb":      begin rw = 1; rdst = 1; done = 1; end
         "i_wb":      begin rw = 1; done = 1; end
         "branch":    begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; done = 1; end
         "jump":      begin pcw = 1; pcsrc = 2'b10; done = 1; end
         "trap":      begin trp = 1; tc = cause; end
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, srcb, aluop, pcsrc,
              done, trp, tc};
   endfunction

   task automatic cyc(input string step, input logic mr, input logic [1:0] cause = 2'b00);
      mem_ready = mr;
      @(negedge clk);
      g_cyc++;
      if (instr_done === 1'b1 && g_done_at == 0) g_done_at = g_cyc;
      check($sformatf("%s@%0d", step, g_cyc), 32'(obs), 32'(vec_for(step, cause)));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("reset_now", 32'(obs), 32'd0);
      @(posedge clk);
      #1;
      check("reset_hold", 32'(obs), 32'd0);
      rst_n = 1'b1;
      g_cyc = 0;
      cyc("start", 1'($urandom));
   endtask

   task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
      logic trapped;
      int   exp_lat;
      trapped = 1'b0;
      exp_lat = 0;
      opcode  = op;
      zero    = 1'($urandom);
      g_cyc   = 0;
      g_done_at = 0;
      for (int i = 0; i < wf; i++) cyc("fetch", 1'b0);
      cyc("fetch_go", 1'b1);
      cyc("decode", 1'($urandom));
      case (op)
         OP_LW: begin
            cyc("mem_addr", 1'($urandom));
            for (int i = 0; i < wm; i++) cyc("mem_rd", 1'b0);
            cyc("mem_rd", 1'b1);
            cyc("mem_wb", 1'($urandom));
            exp_lat = 5;
         end
         OP_SW: begin
            cyc("mem_addr", 1'($urandom));
            for (int i = 0; i < wm; i++) cyc("mem_wr", 1'b0);
            cyc("mem_wr_go", 1'b1);
            exp_lat = 4;
         end
         OP_R: begin
            cyc("exec_r", 1'($urandom));
            cyc("r_wb", 1'($urandom));
            exp_lat = 4;
         end
         OP_ADDI: begin
            cyc("exec_i", 1'($urandom));
            cyc("i_wb", 1'($urandom));
            exp_lat = 4;
         end
         OP_BEQ: begin
            cyc("branch", 1'($urandom));
            exp_lat = 3;
         end
`ifdef MC_CTRL_JUMP_EN
         OP_J: begin
            cyc("jump", 1'($urandom));
            exp_lat = 3;
         end
`endif
         default: begin
            cyc("trap", 1'($urandom), 2'b01);
            cyc("trap", 1'($urandom), 2'b01);
            trapped = 1'b1;
         end
      endcase
      if (trapped) do_reset();
      else if (wf == 0 && wm == 0) check($sformatf("latency_op%b", op), 32'(g_done_at), 32'(exp_lat));
   endtask

   function automatic logic [5:0] illegal_op();
      logic [5:0] o;
      do o = 6'($urandom);
      while (o == OP_R || o == OP_LW || o == OP_SW || o == OP_ADDI || o == OP_BEQ || o == OP_J);
      return o;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] op;
      int         kind;
      do_reset();

      // Directed cases
      run_instr(OP_LW, 0, 0);
      zero = 1'b1;
      run_instr(OP_BEQ, 0, 0);
      run_instr(OP_R, 3, 0);
      run_instr(OP_LW, 3, 3);
      run_instr(6'b111111, 0, 0);
      run_instr(OP_J, 0, 0);
      run_instr(OP_ADDI, 0, 0);
      run_instr(OP_SW, 0, 0);

      // sw whose write never completes
      opcode = OP_SW;
      g_cyc  = 0;
      cyc("fetch_go", 1'b1);
      cyc("decode", 1'b0);
      cyc("mem_addr", 1'b0);
      for (int i = 0; i < TO; i++) cyc("mem_wr", 1'b0);
      for (int i = 0; i < 3; i++) cyc("trap", 1'($urandom), 2'b10);
      do_reset();

      // Reset asserted in the middle of a load's memory read
      opcode = OP_LW;
      g_cyc  = 0;
      cyc("fetch_go", 1'b1);
      cyc("decode", 1'b1);
      cyc("mem_addr", 1'b1);
      mem_ready = 1'b0;
      #2;
      check("mem_rd_before_reset", 32'(obs), 32'(vec_for("mem_rd", 2'b00)));
      do_reset();
      run_instr(OP_LW, 0, 0);

      // Randomized instruction stream
      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 6));
         case (kind)
            0: op = OP_LW;
            1: op = OP_SW;
            2: op = OP_R;
            3: op = OP_ADDI;
            4: op = OP_BEQ;
            5: op = OP_J;
            default: op = illegal_op();
         endcase
         run_instr(op,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TO - 1)) : 0,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TO - 1)) : 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
